// File: rtl/fpga_board_status_ctrl.sv
// Board-level reset conditioning, heartbeat prescaler, sticky SoC exit-status
// latch and a four-mode registered LED bank with a blink-code display.
module fpga_board_status_ctrl #(
    parameter int NUM_LEDS    = 4,
    parameter int TICK_DIV_W  = 24,
    parameter int EXIT_W      = 32,
    parameter int RST_STRETCH = 16,
    parameter int BLINK_W     = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic                soc_rst_no,
    input  logic                exit_valid_i,
    input  logic [EXIT_W-1:0]   exit_value_i,
    input  logic                clear_i,
    input  logic [1:0]          led_mode_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                tick_o,
    output logic                exit_done_o,
    output logic                exit_pass_o,
    output logic [EXIT_W-1:0]   exit_code_o
);

    localparam int STRETCH_W = (RST_STRETCH > 1) ? $clog2(RST_STRETCH) : 1;
    localparam logic [STRETCH_W-1:0] STRETCH_LAST = STRETCH_W'(RST_STRETCH - 1);
    localparam logic [STRETCH_W-1:0] STRETCH_ONE  = STRETCH_W'(1);
    localparam logic [BLINK_W:0]     COUNT_ONE    = (BLINK_W+1)'(1);
    localparam int STATUS_N = (NUM_LEDS < 4) ? NUM_LEDS : 4;
    localparam int CODE_N   = (NUM_LEDS < EXIT_W) ? NUM_LEDS : EXIT_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP
    } blink_state_e;

    logic [1:0]            rst_sync_q;
    logic [STRETCH_W-1:0]  stretch_q;
    logic                  soc_rst_q;
    logic [TICK_DIV_W-1:0] div_q;
    logic                  tick_q;
    logic                  heartbeat;
    logic                  exit_done_q;
    logic                  exit_pass_q;
    logic [EXIT_W-1:0]     exit_code_q;
    blink_state_e          state_q;
    blink_state_e          state_d;
    logic [BLINK_W:0]      count_q;
    logic [BLINK_W:0]      count_d;
    logic [BLINK_W:0]      count_load;
    logic [1:0]            gap_q;
    logic [1:0]            gap_d;
    logic [3:0]            status_bits;
    logic [NUM_LEDS-1:0]   status_leds;
    logic [NUM_LEDS-1:0]   code_leds;
    logic [NUM_LEDS-1:0]   led_d;
    logic [NUM_LEDS-1:0]   led_q;

    // The stretch counter only starts once the synchronised reset has released,
    // so soc_rst_no rises a fixed number of edges after rst_ni is first seen high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rst_sync_q <= 2'b00;
            stretch_q  <= '0;
            soc_rst_q  <= 1'b0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
            if (rst_sync_q[1] && (stretch_q != STRETCH_LAST)) begin
                stretch_q <= stretch_q + STRETCH_ONE;
            end
            soc_rst_q <= rst_sync_q[1] && (stretch_q == STRETCH_LAST);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_q + TICK_DIV_W'(1);
            tick_q <= &div_q;
        end
    end

    assign heartbeat = div_q[TICK_DIV_W-1];

    // Clear has priority; once latched the status stays put until cleared.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            exit_done_q <= 1'b0;
            exit_pass_q <= 1'b0;
            exit_code_q <= '0;
        end else if (clear_i) begin
            exit_done_q <= 1'b0;
            exit_pass_q <= 1'b0;
            exit_code_q <= '0;
        end else if (soc_rst_q && !exit_done_q && exit_valid_i) begin
            exit_done_q <= 1'b1;
            exit_pass_q <= (exit_value_i == '0);
            exit_code_q <= exit_value_i;
        end
    end

    assign count_load = {1'b0, exit_code_q[BLINK_W-1:0]} + COUNT_ONE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            gap_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            gap_q   <= gap_d;
        end
    end

    // A missing or cleared exit status overrides any tick-driven progress.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        gap_d   = gap_q;
        if (!exit_done_q || clear_i) begin
            state_d = ST_IDLE;
        end else if (tick_q) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ON;
                    count_d = count_load;
                end
                ST_ON: begin
                    state_d = ST_OFF;
                end
                ST_OFF: begin
                    if (count_q > COUNT_ONE) begin
                        state_d = ST_ON;
                        count_d = count_q - COUNT_ONE;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = 2'd0;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 2'd3) begin
                        state_d = ST_ON;
                        count_d = count_load;
                    end else begin
                        gap_d = gap_q + 2'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status_bits = {exit_pass_q, exit_done_q, soc_rst_q, heartbeat};
        status_leds = '0;
        status_leds[STATUS_N-1:0] = status_bits[STATUS_N-1:0];
        code_leds = '0;
        if (exit_done_q) begin
            code_leds[CODE_N-1:0] = exit_code_q[CODE_N-1:0];
        end
        case (led_mode_i)
            2'd0:    led_d = status_leds;
            2'd1:    led_d = code_leds;
            2'd2:    led_d = {NUM_LEDS{state_q == ST_ON}};
            default: led_d = {NUM_LEDS{heartbeat}};
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign soc_rst_no  = soc_rst_q;
    assign tick_o      = tick_q;
    assign exit_done_o = exit_done_q;
    assign exit_pass_o = exit_pass_q;
    assign exit_code_o = exit_code_q;
    assign led_o       = led_q;

endmodule

// File: tb/tb_fpga_board_status_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a timing-level model.
module tb_fpga_board_status_ctrl;

    localparam int NUM_LEDS    = 4;
    localparam int TICK_DIV_W  = 3;
    localparam int EXIT_W      = 32;
    localparam int RST_STRETCH = 4;
    localparam int BLINK_W     = 4;
    localparam int TICK_PERIOD = 1 << TICK_DIV_W;

    logic                clk_i        = 1'b0;
    logic                rst_ni       = 1'b0;
    logic                exit_valid_i = 1'b0;
    logic [EXIT_W-1:0]   exit_value_i = '0;
    logic                clear_i      = 1'b0;
    logic [1:0]          led_mode_i   = 2'd0;
    logic                soc_rst_no;
    logic [NUM_LEDS-1:0] led_o;
    logic                tick_o;
    logic                exit_done_o;
    logic                exit_pass_o;
    logic [EXIT_W-1:0]   exit_code_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Model state: edges since release, cycles since reset, blink phase.
    int                m_rel    = 0;
    int                m_cyc    = 0;
    bit                m_active = 1'b0;
    int                m_phase  = 0;
    int                m_n      = 1;
    logic              m_done   = 1'b0;
    logic              m_pass   = 1'b0;
    logic [EXIT_W-1:0] m_code   = '0;
    logic [3:0]        m_led    = 4'h0;

    fpga_board_status_ctrl #(
        .NUM_LEDS    (NUM_LEDS),
        .TICK_DIV_W  (TICK_DIV_W),
        .EXIT_W      (EXIT_W),
        .RST_STRETCH (RST_STRETCH),
        .BLINK_W     (BLINK_W)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .soc_rst_no   (soc_rst_no),
        .exit_valid_i (exit_valid_i),
        .exit_value_i (exit_value_i),
        .clear_i      (clear_i),
        .led_mode_i   (led_mode_i),
        .led_o        (led_o),
        .tick_o       (tick_o),
        .exit_done_o  (exit_done_o),
        .exit_pass_o  (exit_pass_o),
        .exit_code_o  (exit_code_o)
    );

    initial forever #5 clk_i = ~clk_i;

    function automatic bit soc_of(input int rel);
        return rel >= (2 + RST_STRETCH);
    endfunction

    function automatic bit tick_of(input int cyc);
        return (cyc > 0) && ((cyc % TICK_PERIOD) == 0);
    endfunction

    function automatic bit hb_of(input int cyc);
        return (cyc % TICK_PERIOD) >= (TICK_PERIOD / 2);
    endfunction

    function automatic bit on_of(input bit act, input int ph, input int n);
        return act && (ph < 2 * n) && ((ph % 2) == 0);
    endfunction

    function automatic logic [3:0] led_model(input logic [1:0] mode);
        case (mode)
            2'd0:    return {m_pass, m_done, soc_of(m_rel), hb_of(m_cyc)};
            2'd1:    return m_done ? m_code[3:0] : 4'h0;
            2'd2:    return on_of(m_active, m_phase, m_n) ? 4'hF : 4'h0;
            default: return hb_of(m_cyc) ? 4'hF : 4'h0;
        endcase
    endfunction

    // Blink timing: phase counts ticks since the first ON; period is 2n+4 ticks.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            m_rel    <= 0;
            m_cyc    <= 0;
            m_active <= 1'b0;
            m_phase  <= 0;
            m_n      <= 1;
            m_done   <= 1'b0;
            m_pass   <= 1'b0;
            m_code   <= '0;
            m_led    <= 4'h0;
        end else begin
            m_rel <= (m_rel < 1000) ? m_rel + 1 : m_rel;
            m_cyc <= m_cyc + 1;
            if (clear_i) begin
                m_done <= 1'b0;
                m_pass <= 1'b0;
                m_code <= '0;
            end else if (soc_of(m_rel) && !m_done && exit_valid_i) begin
                m_done <= 1'b1;
                m_pass <= (exit_value_i == 0);
                m_code <= exit_value_i;
            end
            if (!m_done || clear_i) begin
                m_active <= 1'b0;
            end else if (tick_of(m_cyc)) begin
                if (!m_active) begin
                    m_active <= 1'b1;
                    m_phase  <= 0;
                    m_n      <= int'(m_code[BLINK_W-1:0]) + 1;
                end else begin
                    m_phase <= (m_phase + 1) % (2 * m_n + 4);
                end
            end
            m_led <= led_model(led_mode_i);
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (cmp_en) begin
            check_output("soc_rst_no", soc_rst_no, soc_of(m_rel));
            check_output("tick_o", tick_o, tick_of(m_cyc));
            check_output("exit_done_o", exit_done_o, m_done);
            check_output("exit_pass_o", exit_pass_o, m_pass);
            check_output("exit_code_o", exit_code_o, m_code);
            check_output("led_o", led_o, m_led);
        end
    end

    task automatic apply_stimulus(input logic valid, input logic [EXIT_W-1:0] value,
                                  input logic clear, input logic [1:0] mode);
        @(negedge clk_i);
        #1;
        exit_valid_i = valid;
        exit_value_i = value;
        clear_i      = clear;
        led_mode_i   = mode;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  toggles;
        int  on_cnt;
        int  rises;
        bit  prev;
        bit  found;
        int  r;

        repeat (3) @(negedge clk_i);
        cmp_en = 1'b1;
        check_output("reset_soc", soc_rst_no, 0);
        check_output("reset_led", led_o, 0);
        check_output("reset_tick", tick_o, 0);
        check_output("reset_done", exit_done_o, 0);

        #1 rst_ni = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            check_output("release_soc", soc_rst_no, (k >= 6));
        end

        #1 rst_ni = 1'b0;
        #2 rst_ni = 1'b1;
        check_output("pulse_soc", soc_rst_no, 0);
        exit_valid_i = 1'b1;
        exit_value_i = 32'h5;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk_i);
            check_output("restart_soc", soc_rst_no, (k >= 6));
            if (k == 4) begin
                #1 exit_valid_i = 1'b0;
            end
        end
        check_output("early_exit_done", exit_done_o, 0);

        #1 exit_valid_i = 1'b1; exit_value_i = 32'h0;
        @(negedge clk_i);
        check_output("latch_done", exit_done_o, 1);
        check_output("latch_pass", exit_pass_o, 1);
        #1 exit_value_i = 32'h5;
        @(negedge clk_i);
        check_output("sticky_code", exit_code_o, 0);
        check_output("sticky_done", exit_done_o, 1);
        #1 clear_i = 1'b1; exit_value_i = 32'h7;
        @(negedge clk_i);
        check_output("clear_done", exit_done_o, 0);
        check_output("clear_code", exit_code_o, 0);
        check_output("clear_pass", exit_pass_o, 0);

        #1 clear_i = 1'b0; exit_valid_i = 1'b1; exit_value_i = 32'h0; led_mode_i = 2'd0;
        @(negedge clk_i);
        #1 exit_valid_i = 1'b0;
        @(negedge clk_i);
        check_output("status_upper", led_o[3:1], 3'b111);
        toggles = 0;
        prev    = led_o[0];
        repeat (8) begin
            @(negedge clk_i);
            if (led_o[0] != prev) toggles++;
            prev = led_o[0];
        end
        check_output("status_hb_toggles", toggles, 2);

        #1 led_mode_i = 2'd3;
        on_cnt = 0;
        toggles = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (led_o == 4'hF) on_cnt++;
            if (led_o != 4'hF && led_o != 4'h0) toggles++;
        end
        check_output("lamp_on_cycles", on_cnt, 4);
        check_output("lamp_split_bits", toggles, 0);

        apply_stimulus(1'b0, 32'h0, 1'b1, 2'd3);
        apply_stimulus(1'b1, 32'hDEADBEE3, 1'b0, 2'd3);
        apply_stimulus(1'b0, 32'h0, 1'b0, 2'd1);
        @(negedge clk_i);
        check_output("code_mode_led", led_o, 4'b0011);

        apply_stimulus(1'b0, 32'h0, 1'b1, 2'd1);
        apply_stimulus(1'b1, 32'h2, 1'b0, 2'd2);
        apply_stimulus(1'b0, 32'h0, 1'b0, 2'd2);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk_i);
            if (led_o == 4'hF) found = 1'b1;
        end
        check_output("blink_start", found, 1);
        on_cnt = 0;
        rises  = 0;
        prev   = 1'b1;
        repeat (80) begin
            @(negedge clk_i);
            if (led_o == 4'hF) on_cnt++;
            if (led_o == 4'hF && !prev) rises++;
            prev = (led_o == 4'hF);
        end
        check_output("blink_on_cycles", on_cnt, 24);
        check_output("blink_on_ticks", rises, 3);
        #1 clear_i = 1'b1;
        @(negedge clk_i);
        #1 clear_i = 1'b0;
        @(negedge clk_i);
        check_output("blink_clear_led", led_o, 4'h0);

        repeat (3000) begin
            @(negedge clk_i);
            #1;
            r = int'($urandom_range(0, 999));
            rst_ni       = (r >= 3);
            exit_valid_i = ($urandom_range(0, 19) == 0);
            exit_value_i = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            clear_i      = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 49) == 0) led_mode_i = 2'($urandom_range(0, 3));
        end
        @(negedge clk_i);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
